// File: rtl/spi_frame_pkg.sv
// Shared frame layout, widths and controller state encoding for the SPI bus sequencer.
// Field positions are frame bit indices; bit 15 goes out first (C1).
package spi_frame_pkg;

  localparam int FRAME_BITS = 16;
  localparam int DATA_BITS  = 8;

  localparam int WR       = 15;
  localparam int EXT_ADDR = 14;
  localparam int RSVD     = 11;
  localparam int REG_ADDR = 10;
  localparam int DATA     = 7;

  typedef enum logic [2:0] {IDLE, GRANT, SHIFT, GAP, DONE} seq_state_e;

  // Address fields go out LSB first while data goes out MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(
    input logic                 wr,
    input logic [2:0]           ext,
    input logic [2:0]           reg_a,
    input logic [DATA_BITS-1:0] data
  );
    logic [FRAME_BITS-1:0] f;
    f       = '0;
    f[WR]   = wr;
    for (int b = 0; b < 3; b++) begin
      f[EXT_ADDR-b] = ext[b];
      f[REG_ADDR-b] = reg_a[b];
    end
    f[RSVD] = 1'b0;
    f[DATA -: DATA_BITS] = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_bus_sequencer_if.sv
// Requester-side command/completion signals plus the shared SPI slave bus.
// Requester handshake: req is a level seen only in IDLE; gnt pulses one cycle while the command is latched, done pulses one cycle with rdata/err valid.
interface spi_bus_sequencer_if
  import spi_frame_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   wr;
  logic [3*NUM_REQ-1:0] ext_addr;
  logic [3*NUM_REQ-1:0] reg_addr;
  logic [8*NUM_REQ-1:0] wdata;
  logic [NUM_REQ-1:0]   gnt;
  logic [NUM_REQ-1:0]   done;
  logic [7:0]           rdata;
  logic                 busy;
  logic                 err;
  logic                 cs;
  logic                 mosi;
  logic                 miso;
  logic                 miso_oe;
  seq_state_e           state_dbg;

  modport master (
    input  req, wr, ext_addr, reg_addr, wdata, miso, miso_oe,
    output gnt, done, rdata, busy, err, cs, mosi, state_dbg
  );

  modport slave (
    output req, wr, ext_addr, reg_addr, wdata, miso, miso_oe,
    input  gnt, done, rdata, busy, err, cs, mosi, state_dbg
  );

endinterface

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module spi_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       valid
);

  int idx;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_bus_sequencer.sv
// Round-robin SPI master: one 16-bit command frame out, one 8-bit reply in.
// Optional no-response detection is enabled by defining SPI_SEQ_NORESP_EN.
module spi_bus_sequencer
  import spi_frame_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                sclk,
  input  logic                rst,
  spi_bus_sequencer_if.master bus
);

  localparam int PW = $clog2(NUM_REQ);

  seq_state_e            state, state_nx;
  logic [3:0]            cnt;
  logic [PW-1:0]         ptr, win_idx;
  logic [NUM_REQ-1:0]    win_oh, win_q;
  logic                  win_valid;
  logic [FRAME_BITS-1:0] frame_q, frame_nx;
  logic [DATA_BITS-1:0]  sh_q, sh_nx, rdata_q;
  logic                  cs_q, mosi_q, capture, rx_bit, noresp;
  logic                  sel_wr;
  logic [2:0]            sel_ext, sel_reg;
  logic [7:0]            sel_wdata;

  spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (win_oh),
    .valid (win_valid)
  );

  always_ff @(posedge sclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    bus.gnt  = '0;
    bus.done = '0;
    bus.busy = (state != IDLE);
    case (state)
      IDLE:    if (win_valid) state_nx = GRANT;
      GRANT: begin
        bus.gnt  = win_q;
        state_nx = SHIFT;
      end
      SHIFT:   if (cnt == 4'd0) state_nx = GAP;
      GAP:     state_nx = DONE;
      DONE: begin
        bus.done = win_q;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win_oh[i]) win_idx = PW'(i);
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_ext   = '0;
    sel_reg   = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_q[i]) begin
        sel_wr    = bus.wr[i];
        sel_ext   = bus.ext_addr[3*i +: 3];
        sel_reg   = bus.reg_addr[3*i +: 3];
        sel_wdata = bus.wdata[8*i +: 8];
      end
    end
    frame_nx = build_frame(sel_wr, sel_ext, sel_reg, sel_wdata);
  end

  // Reply window is C10..C16 in SHIFT (counter 6..0) plus the GAP cycle.
  assign capture = ((state == SHIFT) && (cnt <= 4'd6)) || (state == GAP);
  assign rx_bit  = bus.miso & bus.miso_oe;
  assign sh_nx   = frame_q[WR] ? {sh_q[DATA_BITS-2:0], rx_bit}
                               : {rx_bit, sh_q[DATA_BITS-1:1]};

  always_ff @(posedge sclk) begin
    if (rst) begin
      ptr     <= '0;
      win_q   <= '0;
      frame_q <= '0;
      cnt     <= '0;
      cs_q    <= 1'b0;
      mosi_q  <= 1'b0;
      sh_q    <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            win_q <= win_oh;
            ptr   <= (win_idx == PW'(NUM_REQ-1)) ? '0 : win_idx + PW'(1);
          end
        end
        GRANT: begin
          frame_q <= frame_nx;
          cnt     <= 4'd15;
          cs_q    <= 1'b1;
          mosi_q  <= frame_nx[FRAME_BITS-1];
          sh_q    <= '0;
        end
        SHIFT: begin
          if (capture) sh_q <= sh_nx;
          if (cnt == 4'd0) begin
            cs_q   <= 1'b0;
            mosi_q <= 1'b0;
          end else begin
            cnt    <= cnt - 4'd1;
            mosi_q <= frame_q[cnt - 4'd1];
          end
        end
        GAP: begin
          sh_q    <= sh_nx;
          rdata_q <= noresp ? '0 : sh_nx;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_SEQ_NORESP_EN
  logic [3:0] oe_cnt;
  logic       err_q;

  assign noresp = ((oe_cnt + {3'b000, bus.miso_oe}) == 4'd0);

  always_ff @(posedge sclk) begin
    if (rst) begin
      oe_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == GRANT)
        oe_cnt <= '0;
      else if (capture && bus.miso_oe)
        oe_cnt <= oe_cnt + 4'd1;
      if (state == GAP) err_q <= noresp;
    end
  end

  assign bus.err = err_q;
`else
  assign noresp  = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.cs        = cs_q;
  assign bus.mosi      = mosi_q;
  assign bus.rdata     = rdata_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_spi_bus_sequencer.sv
// Directed bench for spi_bus_sequencer: table of single transactions plus reset, round-robin and request-drop sequences.
module tb_spi_bus_sequencer;
  import spi_frame_pkg::*;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  always #5 sclk = ~sclk;

  spi_bus_sequencer_if #(.NUM_REQ(4)) bus ();

  spi_bus_sequencer #(.NUM_REQ(4)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus)
  );

`ifdef SPI_SEQ_NORESP_EN
  localparam logic EXP_NORESP_ERR = 1'b1;
`else
  localparam logic EXP_NORESP_ERR = 1'b0;
`endif

  typedef struct {
    int         r;
    logic       w;
    logic [2:0] e;
    logic [2:0] rg;
    logic [7:0] wd;
    logic [7:0] reply;
    logic       oe;
    logic [15:0] frame;
    logic [7:0] rdata;
    logic       err;
  } vec_t;

  vec_t vecs[5];
  vec_t drop_v;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.req      = '0;
    bus.wr       = '0;
    bus.ext_addr = '0;
    bus.reg_addr = '0;
    bus.wdata    = '0;
    bus.miso     = 1'b0;
    bus.miso_oe  = 1'b0;
  endtask

  // Drives one request from an idle bus and plays the addressed slave.
  task automatic run_txn(input vec_t v);
    logic [15:0] got_frame;
    logic [3:0]  exp_g;
    int          lat;
    bit          got;
    int          cs_hi;
    int          j;
    got_frame = '0;
    exp_g     = 4'b0001 << v.r;
    lat       = 0;
    got       = 1'b0;
    cs_hi     = 0;
    @(negedge sclk);
    clear_inputs();
    bus.wr[v.r]                = v.w;
    bus.ext_addr[3*v.r +: 3]   = v.e;
    bus.reg_addr[3*v.r +: 3]   = v.rg;
    bus.wdata[8*v.r +: 8]      = v.wd;
    bus.req[v.r]               = 1'b1;
    while (!got && lat < 40) begin
      @(negedge sclk);
      lat++;
      if (bus.gnt != 0) got = 1'b1;
    end
    check("gnt_seen", 32'(got), 32'd1);
    if (!got) return;
    check("gnt_latency", 32'(lat), 32'd1);
    check("gnt_onehot", 32'(bus.gnt), 32'(exp_g));
    bus.req = '0;
    for (int n = 1; n <= 17; n++) begin
      @(negedge sclk);
      if (n <= 16) begin
        got_frame[16-n] = bus.mosi;
        if (bus.cs) cs_hi++;
      end else begin
        check("gap_cs_mosi", 32'({bus.cs, bus.mosi}), 32'd0);
      end
      if (n >= 10) begin
        j           = n - 10;
        bus.miso_oe = v.oe;
        bus.miso    = v.oe ? (v.w ? v.reply[7-j] : v.reply[j]) : 1'b1;
      end
    end
    check("frame", 32'(got_frame), 32'(v.frame));
    check("cs_high_cycles", 32'(cs_hi), 32'd16);
    @(negedge sclk);
    bus.miso    = 1'b0;
    bus.miso_oe = 1'b0;
    check("done_at_18", 32'(bus.done), 32'(exp_g));
    check("rdata", 32'(bus.rdata), 32'(v.rdata));
    check("err", 32'(bus.err), 32'(v.err));
    @(negedge sclk);
    check("idle_after", 32'({bus.done, bus.busy}), 32'd0);
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    logic [3:0] g_vec[5];
    int         g_cyc[5];
    int         rr_order[5];
    int         k;
    int         cyc;
    int         t;
    bit         seen;

    vecs[0] = '{0, 1'b0, 3'd2, 3'd5, 8'h00, 8'h75, 1'b1, 16'h2500, 8'h75, 1'b0};
    vecs[1] = '{1, 1'b1, 3'd1, 3'd3, 8'hA5, 8'h35, 1'b1, 16'hC6A5, 8'h35, 1'b0};
    vecs[2] = '{3, 1'b0, 3'd7, 3'd0, 8'hFF, 8'h81, 1'b1, 16'h70FF, 8'h81, 1'b0};
    vecs[3] = '{2, 1'b1, 3'd4, 3'd6, 8'h3C, 8'hC3, 1'b0, 16'h933C, 8'h00, EXP_NORESP_ERR};
    vecs[4] = '{1, 1'b0, 3'd5, 3'd2, 8'h5A, 8'h3E, 1'b1, 16'h525A, 8'h3E, 1'b0};
    drop_v  = '{2, 1'b0, 3'd3, 3'd1, 8'h00, 8'h5C, 1'b1, 16'h6400, 8'h5C, 1'b0};
    rr_order = '{0, 1, 2, 3, 0};

    // Reset values
    clear_inputs();
    rst = 1'b1;
    repeat (3) @(negedge sclk);
    check("rst_cs_mosi", 32'({bus.cs, bus.mosi}), 32'd0);
    check("rst_gnt_done", 32'({bus.gnt, bus.done}), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(IDLE));
    rst = 1'b0;
    @(negedge sclk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // Reset mid-frame at C8 of a grant to requester 2
    @(negedge sclk);
    clear_inputs();
    bus.ext_addr[8:6] = 3'd6;
    bus.wdata[23:16]  = 8'hC9;
    bus.req[2]        = 1'b1;
    t = 0;
    while (bus.gnt == 0 && t < 40) begin
      @(negedge sclk);
      t++;
    end
    check("abort_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    repeat (8) @(negedge sclk);
    check("abort_cs_before", 32'(bus.cs), 32'd1);
    rst = 1'b1;
    @(negedge sclk);
    rst = 1'b0;
    check("abort_cs_low", 32'(bus.cs), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_rdata", 32'(bus.rdata), 32'd0);
    seen = 1'b0;
    repeat (25) begin
      @(negedge sclk);
      if (bus.done != 0) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Round-robin with all requests held; first grant proves pointer is back at 0
    bus.req = 4'hF;
    k   = 0;
    cyc = 0;
    while (k < 5 && cyc < 150) begin
      @(negedge sclk);
      cyc++;
      if (bus.gnt != 0) begin
        g_vec[k] = bus.gnt;
        g_cyc[k] = cyc;
        k++;
        if (k == 5) bus.req = '0;
      end
    end
    check("rr_grants", 32'(k), 32'd5);
    for (int i = 0; i < k; i++) begin
      check("rr_order", 32'(g_vec[i]), 32'(4'b0001 << rr_order[i]));
      if (i > 0) check("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd20);
    end
    t = 0;
    while (bus.busy && t < 40) begin
      @(negedge sclk);
      t++;
    end
    check("rr_drain", 32'(bus.busy), 32'd0);

    // Request dropped right after grant: completes once, never regranted
    run_txn(drop_v);
    seen = 1'b0;
    repeat (30) begin
      @(negedge sclk);
      if (bus.gnt != 0) seen = 1'b1;
    end
    check("drop_no_regnt", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
